// File: rtl/sb_pkg.sv
// Shared types for the posted-write store buffer: FSM states and the buffered entry layout.
package sb_pkg;

    localparam int unsigned SB_WIDTH = 32;
    localparam int unsigned SB_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAINING = 2'd1,
        FLUSHING = 2'd2
    } sb_state_t;

    typedef struct packed {
        logic [SB_WIDTH-1:0] adr;
        logic [SB_WIDTH-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_fifo.sv
// Circular store FIFO: entry storage, read/write pointers and occupancy count.
// All entries are exported so the parent can search them for load forwarding.
module sb_fifo
    import sb_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  sb_entry_t                  push_entry,
    output sb_entry_t                  entries [DEPTH],
    output logic [$clog2(DEPTH)-1:0]   rd_ptr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full_c,
    output logic                       empty_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full_c  = (count == CNT_W'(DEPTH));
    assign empty_c = (count == '0);

    // A push into a full FIFO is only legal when the head leaves on the same edge.
    assign push_ok = push & (~full_c | pop);
    assign pop_ok  = pop & ~empty_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entries <= '{default: '0};
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (push_ok) begin
                entries[wr_ptr] <= push_entry;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the core data port and data memory, with
// youngest-first load forwarding and a flush mode that stalls the core until empty.
module store_buffer
    import sb_pkg::*;
#(
    parameter int unsigned WIDTH = SB_WIDTH,
    parameter int unsigned DEPTH = SB_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemWrite,
    input  logic             MemRead,
    input  logic [WIDTH-1:0] DataAdr,
    input  logic [WIDTH-1:0] WriteData,
    output logic [WIDTH-1:0] ReadData,
    output logic             Stall,
    input  logic             Flush,
    output logic             Empty,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ready,
    output logic [WIDTH-1:0] mem_radr,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    sb_state_t        state;
    sb_entry_t        entries [DEPTH];
    sb_entry_t        head;
    sb_entry_t        push_entry;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             full_c;
    logic             empty_c;
    logic             drain;
    logic             enq;
    logic             hit;
    logic [PTR_W-1:0] fwd_idx;
    logic [WIDTH-1:0] fwd_data;

    sb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (enq),
        .pop        (drain),
        .push_entry (push_entry),
        .entries    (entries),
        .rd_ptr     (rd_ptr),
        .count      (count),
        .full_c     (full_c),
        .empty_c    (empty_c)
    );

    assign head       = entries[rd_ptr];
    assign push_entry = '{adr: SB_WIDTH'(DataAdr), data: SB_WIDTH'(WriteData)};

    assign mem_we    = ~empty_c;
    assign mem_adr   = WIDTH'(head.adr);
    assign mem_wdata = WIDTH'(head.data);
    assign mem_radr  = DataAdr;
    assign Empty     = empty_c;

    assign drain = mem_we & mem_ready;
    assign Stall = (MemWrite & full_c & ~drain) | (state == FLUSHING);
    assign enq   = MemWrite & ~Stall;

    always_comb begin
        count_next = count;
        if (enq && !drain) begin
            count_next = count + CNT_W'(1);
        end else if (drain && !enq) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Walk oldest to youngest so the last match, i.e. the youngest store, wins.
    always_comb begin
        hit      = 1'b0;
        fwd_idx  = '0;
        fwd_data = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            fwd_idx = rd_ptr + PTR_W'(k);
            if ((CNT_W'(k) < count) && (entries[fwd_idx].adr == SB_WIDTH'(DataAdr))) begin
                hit      = 1'b1;
                fwd_data = WIDTH'(entries[fwd_idx].data);
            end
        end
    end

    assign ReadData = (MemRead && hit) ? fwd_data : mem_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (Flush && !empty_c) begin
                        state <= FLUSHING;
                    end else if (!empty_c) begin
                        state <= DRAINING;
                    end
                end
                DRAINING: begin
                    if (Flush && !empty_c) begin
                        state <= FLUSHING;
                    end else if (count_next == '0) begin
                        state <= IDLE;
                    end
                end
                FLUSHING: begin
                    if (count_next == '0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: a queue-based reference model predicts stalls,
// forwarded loads and the in-order memory write stream; a monitor compares them.
module tb_store_buffer;

    localparam int unsigned W = 32;
    localparam int unsigned D = 4;

    typedef struct {
        logic [W-1:0] adr;
        logic [W-1:0] data;
    } ent_t;

    typedef struct {
        logic         stall;
        logic         empty;
        logic         we;
        logic         rd_en;
        logic [W-1:0] rd;
    } cyc_t;

    logic         clk;
    logic         reset;
    logic         MemWrite;
    logic         MemRead;
    logic [W-1:0] DataAdr;
    logic [W-1:0] WriteData;
    logic [W-1:0] ReadData;
    logic         Stall;
    logic         Flush;
    logic         Empty;
    logic         mem_we;
    logic [W-1:0] mem_adr;
    logic [W-1:0] mem_wdata;
    logic         mem_ready;
    logic [W-1:0] mem_radr;
    logic [W-1:0] mem_rdata;

    ent_t model_q[$];
    ent_t wr_q[$];
    cyc_t cyc_q[$];
    logic flushing;
    int   n_total;
    int   n_pass;

    store_buffer #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .Flush     (Flush),
        .Empty     (Empty),
        .mem_we    (mem_we),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_radr  (mem_radr),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One core cycle: drive inputs, predict the response, then advance the model.
    task automatic cycle(input logic mw, input logic mr, input logic [W-1:0] adr,
                         input logic [W-1:0] wd, input logic rdy, input logic fl,
                         input logic [W-1:0] rdata);
        int   cnt;
        logic drn;
        logic stl;
        logic en;
        logic [W-1:0] exp_rd;
        @(negedge clk);
        MemWrite  = mw;
        MemRead   = mr;
        DataAdr   = adr;
        WriteData = wd;
        mem_ready = rdy;
        Flush     = fl;
        mem_rdata = rdata;
        cnt = model_q.size();
        drn = (cnt != 0) && rdy;
        stl = (mw && cnt == int'(D) && !drn) || flushing;
        en  = mw && !stl;
        exp_rd = rdata;
        if (mr) begin
            for (int i = cnt - 1; i >= 0; i--) begin
                if (model_q[i].adr == adr) begin
                    exp_rd = model_q[i].data;
                    break;
                end
            end
        end
        cyc_q.push_back('{stall: stl, empty: (cnt == 0), we: (cnt != 0), rd_en: mr, rd: exp_rd});
        if (en) wr_q.push_back('{adr: adr, data: wd});
        @(posedge clk);
        if (drn) void'(model_q.pop_front());
        if (en) model_q.push_back('{adr: adr, data: wd});
        flushing = flushing ? (model_q.size() != 0) : (fl && cnt != 0);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, rdy, 1'b0, '0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        Flush     = 1'b0;
        mem_ready = 1'b1;
        #1 reset = 1'b0;
        model_q.delete();
        wr_q.delete();
        flushing = 1'b0;
        #1;
        chk("async_rst_mem_we", W'(mem_we), W'(0));
        chk("async_rst_empty", W'(Empty), W'(1));
        chk("async_rst_stall", W'(Stall), W'(0));
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Monitor: per-cycle status from cyc_q, memory writes popped from wr_q as they drain.
    cyc_t rec;
    ent_t exp_w;
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (cyc_q.size() != 0) begin
                rec = cyc_q.pop_front();
                chk("stall", W'(Stall), W'(rec.stall));
                chk("empty", W'(Empty), W'(rec.empty));
                chk("mem_we", W'(mem_we), W'(rec.we));
                chk("mem_radr", mem_radr, DataAdr);
                if (rec.rd_en) chk("read_data", ReadData, rec.rd);
            end
            if (mem_we && mem_ready) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_mem_write", mem_adr, 'x);
                end else begin
                    exp_w = wr_q.pop_front();
                    chk("drain_adr", mem_adr, exp_w.adr);
                    chk("drain_data", mem_wdata, exp_w.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

    logic         r_mw;
    logic         r_mr;
    logic [W-1:0] r_adr;

    initial begin
        n_total   = 0;
        n_pass    = 0;
        flushing  = 1'b0;
        reset     = 1'b0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        DataAdr   = '0;
        WriteData = '0;
        Flush     = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        #25 reset = 1'b1;
        #2;
        chk("reset_empty", W'(Empty), W'(1));
        chk("reset_mem_we", W'(mem_we), W'(0));
        chk("reset_stall", W'(Stall), W'(0));
        chk("reset_mem_adr", mem_adr, '0);
        chk("reset_mem_wdata", mem_wdata, '0);

        // Single store, drained the following cycle.
        cycle(1'b1, 1'b0, 32'd100, 32'd7, 1'b1, 1'b0, '0);
        idle(2, 1'b1);

        // Fill with memory blocked; the fifth store stalls until mem_ready rises.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, W'(96 + 4 * i), W'(i + 1), 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 32'd112, 32'd5, 1'b1, 1'b0, '0);
        idle(6, 1'b1);

        // Forwarding: youngest of two same-address stores wins; a miss passes mem_rdata.
        cycle(1'b1, 1'b0, 32'd96, 32'd3, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 32'd96, 32'd5, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 32'd96, '0, 1'b0, 1'b0, 32'h1234);
        cycle(1'b0, 1'b1, 32'd200, '0, 1'b0, 1'b0, 32'hAA);
        idle(3, 1'b1);

        // Flush with three entries and a toggling memory; stores attempted meanwhile.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, W'(400 + 4 * i), W'(i + 10), 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'd300, W'(i), (i % 2) == 0, 1'b0, '0);
        idle(3, 1'b1);

        // Reset asserted between edges while two entries are waiting to drain.
        cycle(1'b1, 1'b0, 32'd500, 32'd1, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 32'd504, 32'd2, 1'b0, 1'b0, '0);
        async_reset();
        idle(3, 1'b1);

        // Randomized traffic over a small address pool to exercise forwarding and wrap.
        for (int i = 0; i < 2000; i++) begin
            r_mw  = ($urandom_range(0, 99) < 50);
            r_mr  = !r_mw && ($urandom_range(0, 99) < 40);
            r_adr = W'($urandom_range(0, 7) * 4);
            cycle(r_mw, r_mr, r_adr, W'($urandom), ($urandom_range(0, 99) < 45),
                  ($urandom_range(0, 99) < 3), W'($urandom));
        end
        idle(12, 1'b1);
        chk("drains_outstanding", W'(wr_q.size()), W'(0));
        chk("final_empty", W'(Empty), W'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
